// File: rtl/alu_result_buffer.sv
// Result collector for the ALU execution units: picks one flagged result per
// cycle by fixed priority and queues it in a FWFT FIFO with sticky error tracking.
module alu_result_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [WIDTH-1:0]         Arith_OUT,
  input  logic                     Arith_Flag,
  input  logic [WIDTH-1:0]         Logic_OUT,
  input  logic                     Logic_Flag,
  input  logic [WIDTH-1:0]         CMP_OUT,
  input  logic                     CMP_Flag,
  input  logic [WIDTH-1:0]         Shift_OUT,
  input  logic                     Shift_Flag,
  input  logic                     Out_Ready,
  input  logic                     Clr_Err,
  output logic                     Out_Valid,
  output logic [WIDTH-1:0]         Out_Data,
  output logic [1:0]               Out_Src,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Full,
  output logic                     Empty,
  output logic                     Conflict_Err,
  output logic                     Overflow_Err,
  output logic [7:0]               Drop_Count
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    SRC_ARITH = 2'b00,
    SRC_LOGIC = 2'b01,
    SRC_CMP   = 2'b10,
    SRC_SHIFT = 2'b11
  } src_e;

  typedef struct packed {
    logic [1:0]       src;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t               mem [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [PW:0]          count_q;

  entry_t               sel_entry;
  logic                 push_req;
  logic                 conflict;
  logic                 pop;
  logic                 do_push;
  logic                 drop;

  // NOTE: every variable gets a default before the priority chain so no latch is inferred.
  always_comb begin
    sel_entry = '0;
    if (Arith_Flag) begin
      sel_entry.src  = SRC_ARITH;
      sel_entry.data = Arith_OUT;
    end else if (Logic_Flag) begin
      sel_entry.src  = SRC_LOGIC;
      sel_entry.data = Logic_OUT;
    end else if (CMP_Flag) begin
      sel_entry.src  = SRC_CMP;
      sel_entry.data = CMP_OUT;
    end else if (Shift_Flag) begin
      sel_entry.src  = SRC_SHIFT;
      sel_entry.data = Shift_OUT;
    end
  end

  assign push_req = Arith_Flag | Logic_Flag | CMP_Flag | Shift_Flag;
  assign conflict = (Arith_Flag & Logic_Flag) | (Arith_Flag & CMP_Flag) |
                    (Arith_Flag & Shift_Flag) | (Logic_Flag & CMP_Flag) |
                    (Logic_Flag & Shift_Flag) | (CMP_Flag & Shift_Flag);

  assign Empty     = (count_q == '0);
  assign Full      = (count_q == (PW+1)'(DEPTH));
  assign Count     = count_q;
  assign Out_Valid = ~Empty;
  assign Out_Data  = mem[rd_ptr].data;
  assign Out_Src   = mem[rd_ptr].src;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop     = Out_Valid & Out_Ready;
  assign do_push = push_req & (~Full | pop);
  assign drop    = push_req & Full & ~pop;

  // NOTE: storage is reset too, so Out_Data reads 0 after reset rather than stale data.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= sel_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Error events take precedence over a simultaneous clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Conflict_Err <= 1'b0;
      Overflow_Err <= 1'b0;
      Drop_Count   <= '0;
    end else begin
      if (conflict)     Conflict_Err <= 1'b1;
      else if (Clr_Err) Conflict_Err <= 1'b0;

      if (drop)         Overflow_Err <= 1'b1;
      else if (Clr_Err) Overflow_Err <= 1'b0;

      if (drop) begin
        if (Clr_Err)                  Drop_Count <= 8'd1;
        else if (Drop_Count != 8'hFF) Drop_Count <= Drop_Count + 1'b1;
      end else if (Clr_Err) begin
        Drop_Count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer: stimulus queues expected entries,
// a negedge monitor compares every handshake against the queue.
module tb_alu_result_buffer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [1:0]  src;
    logic [15:0] data;
  } exp_t;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic [WIDTH-1:0]  Arith_OUT = '0, Logic_OUT = '0, CMP_OUT = '0, Shift_OUT = '0;
  logic              Arith_Flag = 0, Logic_Flag = 0, CMP_Flag = 0, Shift_Flag = 0;
  logic              Out_Ready = 0, Clr_Err = 0;
  logic              Out_Valid, Full, Empty, Conflict_Err, Overflow_Err;
  logic [WIDTH-1:0]  Out_Data;
  logic [1:0]        Out_Src;
  logic [2:0]        Count;
  logic [7:0]        Drop_Count;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  alu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .Arith_OUT(Arith_OUT), .Arith_Flag(Arith_Flag),
    .Logic_OUT(Logic_OUT), .Logic_Flag(Logic_Flag),
    .CMP_OUT(CMP_OUT), .CMP_Flag(CMP_Flag),
    .Shift_OUT(Shift_OUT), .Shift_Flag(Shift_Flag),
    .Out_Ready(Out_Ready), .Clr_Err(Clr_Err),
    .Out_Valid(Out_Valid), .Out_Data(Out_Data), .Out_Src(Out_Src),
    .Count(Count), .Full(Full), .Empty(Empty),
    .Conflict_Err(Conflict_Err), .Overflow_Err(Overflow_Err),
    .Drop_Count(Drop_Count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    Arith_Flag = 0; Logic_Flag = 0; CMP_Flag = 0; Shift_Flag = 0;
    Out_Ready = 0; Clr_Err = 0;
  endtask

  task automatic exp_push(input logic [1:0] src, input logic [15:0] data);
    exp_t e;
    e.src  = src;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted handshake must match the oldest expected entry.
  always @(negedge CLK) begin
    if (RST && Out_Valid && Out_Ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL pop_unexpected: got %0h src %0d expected no entry", Out_Data, Out_Src);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pop_data", 32'(Out_Data), 32'(e.data));
        check("pop_src", 32'(Out_Src), 32'(e.src));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #12;
    check("rst_valid", 32'(Out_Valid), 0);
    check("rst_data", 32'(Out_Data), 0);
    check("rst_src", 32'(Out_Src), 0);
    check("rst_empty", 32'(Empty), 1);
    check("rst_full", 32'(Full), 0);
    check("rst_count", 32'(Count), 0);
    RST = 1;
    tick();

    // Single result, then pop
    Logic_Flag = 1; Logic_OUT = 16'h00F0; exp_push(2'b01, 16'h00F0);
    tick(); idle();
    check("single_count", 32'(Count), 1);
    check("single_valid", 32'(Out_Valid), 1);
    check("single_data", 32'(Out_Data), 32'h00F0);
    check("single_src", 32'(Out_Src), 1);
    Out_Ready = 1;
    tick(); idle();
    check("single_empty", 32'(Empty), 1);

    // Conflict priority: arith beats shift
    Arith_Flag = 1; Arith_OUT = 16'h1234; Shift_Flag = 1; Shift_OUT = 16'hABCD;
    exp_push(2'b00, 16'h1234);
    tick(); idle();
    check("conf_count", 32'(Count), 1);
    check("conf_err", 32'(Conflict_Err), 1);
    check("conf_drop", 32'(Drop_Count), 0);
    check("conf_data", 32'(Out_Data), 32'h1234);
    check("conf_src", 32'(Out_Src), 0);
    Out_Ready = 1;
    tick(); idle();
    Clr_Err = 1;
    tick(); idle();
    check("conf_clr", 32'(Conflict_Err), 0);
    check("conf_clr_empty", 32'(Empty), 1);

    // Overflow: six pushes into four slots
    for (int i = 1; i <= 6; i++) begin
      Logic_Flag = 1; Logic_OUT = 16'(i);
      if (i <= 4) exp_push(2'b01, 16'(i));
      tick();
    end
    idle();
    check("ovf_full", 32'(Full), 1);
    check("ovf_count", 32'(Count), 4);
    check("ovf_err", 32'(Overflow_Err), 1);
    check("ovf_drop", 32'(Drop_Count), 2);

    // Full with simultaneous push and pop
    CMP_Flag = 1; CMP_OUT = 16'h0055; Out_Ready = 1; exp_push(2'b10, 16'h0055);
    tick(); idle();
    check("fpp_count", 32'(Count), 4);
    check("fpp_drop", 32'(Drop_Count), 2);
    check("fpp_head", 32'(Out_Data), 2);

    // Clear colliding with a drop: the drop wins
    Clr_Err = 1; Logic_Flag = 1; Logic_OUT = 16'h0007;
    tick(); idle();
    check("clr_ev_ovf", 32'(Overflow_Err), 1);
    check("clr_ev_drop", 32'(Drop_Count), 1);
    Clr_Err = 1;
    tick(); idle();
    check("clr_ovf", 32'(Overflow_Err), 0);
    check("clr_drop", 32'(Drop_Count), 0);
    check("clr_conf", 32'(Conflict_Err), 0);
    check("clr_count", 32'(Count), 4);
    check("clr_head", 32'(Out_Data), 2);

    // Drain across the pointer wrap
    Out_Ready = 1;
    for (int i = 0; i < 4; i++) tick();
    idle();
    check("drain_empty", 32'(Empty), 1);
    check("drain_sb", 32'(exp_q.size()), 0);

    // Async reset mid-stream with three entries held
    Arith_Flag = 1; Arith_OUT = 16'h0A0A; Logic_Flag = 1; Logic_OUT = 16'h0B0B;
    tick(); idle();
    Logic_Flag = 1; Logic_OUT = 16'h0C0C; tick();
    Logic_OUT = 16'h0D0D; tick(); idle();
    check("pre_rst_count", 32'(Count), 3);
    check("pre_rst_conf", 32'(Conflict_Err), 1);
    #2;
    RST = 0;
    #1;
    exp_q.delete();
    check("arst_valid", 32'(Out_Valid), 0);
    check("arst_count", 32'(Count), 0);
    check("arst_data", 32'(Out_Data), 0);
    check("arst_conf", 32'(Conflict_Err), 0);
    check("arst_ovf", 32'(Overflow_Err), 0);
    check("arst_drop", 32'(Drop_Count), 0);
    RST = 1;
    tick();
    Shift_Flag = 1; Shift_OUT = 16'h0BEE; exp_push(2'b11, 16'h0BEE);
    tick(); idle();
    check("post_rst_count", 32'(Count), 1);
    check("post_rst_data", 32'(Out_Data), 32'h0BEE);
    check("post_rst_src", 32'(Out_Src), 3);
    Out_Ready = 1;
    tick(); idle();
    check("post_rst_empty", 32'(Empty), 1);
    check("final_sb", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
